// File: rtl/eth_mac_cfg_ctrl_if.sv
// Host register write bus feeding the MAC
// configuration sequencer.
interface eth_mac_cfg_ctrl_if;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;

  modport master (
    output cfg_wr_en,
    output cfg_wr_addr,
    output cfg_wr_data
  );

  modport slave (
    input cfg_wr_en,
    input cfg_wr_addr,
    input cfg_wr_data
  );
endinterface

// File: rtl/eth_mac_cfg_ctrl.sv
// Shadow/active MAC config with safe-point apply
// sequencing for the 10G MAC on clk156.
module eth_mac_cfg_ctrl #(
  parameter logic [47:0] SRC_MAC      = 48'h001122334455,
  parameter int          MTU          = 1518,
  parameter int          DRAIN_CYCLES = 16,
  parameter int          IDLE_TIMEOUT = 1024
) (
  input  logic              clk156,
  input  logic              sys_rst,
  eth_mac_cfg_ctrl_if.slave host,
  input  logic              link_up,
  input  logic              tx_idle,
  input  logic              rx_idle,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_timeout,
  output logic [79:0]       mac_tx_configuration_vector,
  output logic [79:0]       mac_rx_configuration_vector
);
  localparam int QW = $clog2(IDLE_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    DOWN, RUN, QUIESCE, DRAIN, APPLY
  } state_t;

  typedef struct packed {
    logic [47:0] mac;
    logic [14:0] mtu;
    logic        tx_en;
    logic        rx_en;
    logic        jumbo;
    logic        vlan;
  } mac_cfg_t;

  localparam mac_cfg_t CFG_RST = '{
    mac:   SRC_MAC,
    mtu:   15'(MTU),
    tx_en: 1'b1,
    rx_en: 1'b1,
    jumbo: 1'b1,
    vlan:  1'b1
  };

  state_t        state, nxt;
  mac_cfg_t      shadow, shadow_n;
  mac_cfg_t      active, active_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          pending;
  logic          commit;
  logic          busy;
  logic          idle;
  logic          run_en;

  function automatic logic [79:0] vec(
    input mac_cfg_t c,
    input logic     en,
    input logic     tx
  );
    logic [79:0] v;
    v        = '0;
    v[79:32] = c.mac;
    v[30:16] = c.mtu;
    v[4]     = c.jumbo;
    v[2]     = c.vlan;
    v[1]     = en;
    if (tx) v[10] = 1'b1;
    else    v[9:8] = 2'b11;
    return v;
  endfunction

  assign idle   = tx_idle && rx_idle;
  assign busy   = state inside {QUIESCE, DRAIN, APPLY};
  assign commit = host.cfg_wr_en &&
                  host.cfg_wr_addr == 2'd3 &&
                  host.cfg_wr_data[4];

  always_comb begin
    shadow_n = shadow;
    if (host.cfg_wr_en) begin
      unique case (1'b1)
        host.cfg_wr_addr == 2'd0:
          shadow_n.mac[31:0] = host.cfg_wr_data;
        host.cfg_wr_addr == 2'd1:
          shadow_n.mac[47:32] = host.cfg_wr_data[15:0];
        host.cfg_wr_addr == 2'd2:
          shadow_n.mtu = host.cfg_wr_data[14:0];
        host.cfg_wr_addr == 2'd3: begin
          shadow_n.tx_en = host.cfg_wr_data[0];
          shadow_n.rx_en = host.cfg_wr_data[1];
          shadow_n.jumbo = host.cfg_wr_data[2];
          shadow_n.vlan  = host.cfg_wr_data[3];
        end
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      DOWN:
        if (commit)       nxt = APPLY;
        else if (link_up) nxt = RUN;
      RUN:
        if (!link_up)               nxt = DOWN;
        else if (commit || pending) nxt = QUIESCE;
      QUIESCE:
        if (idle || qcnt == QW'(IDLE_TIMEOUT - 1))
          nxt = DRAIN;
      DRAIN:
        if (dcnt == DW'(DRAIN_CYCLES - 1))
          nxt = APPLY;
      APPLY:
        nxt = link_up ? RUN : DOWN;
      default:
        nxt = DOWN;
    endcase
  end

  always_comb begin
    qcnt_n = '0;
    dcnt_n = '0;
    if (state == QUIESCE) qcnt_n = qcnt + QW'(1);
    if (state == DRAIN)   dcnt_n = dcnt + DW'(1);
  end

  assign active_n = (state == APPLY) ? shadow : active;
  // Coming up from DOWN, enables wait one RUN cycle.
  assign run_en = (nxt == RUN) && (state != DOWN);

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state       <= DOWN;
      shadow      <= CFG_RST;
      active      <= CFG_RST;
      pending     <= 1'b0;
      qcnt        <= '0;
      dcnt        <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_timeout <= 1'b0;
      mac_tx_configuration_vector <=
        vec(CFG_RST, 1'b0, 1'b1);
      mac_rx_configuration_vector <=
        vec(CFG_RST, 1'b0, 1'b0);
    end else begin
      state  <= nxt;
      shadow <= shadow_n;
      active <= active_n;
      qcnt   <= (nxt == QUIESCE) ? qcnt_n : '0;
      dcnt   <= (nxt == DRAIN) ? dcnt_n : '0;
      if (nxt == QUIESCE && state != QUIESCE)
        pending <= 1'b0;
      else if (commit && busy)
        pending <= 1'b1;
      cfg_busy    <= nxt inside {QUIESCE, DRAIN, APPLY};
      cfg_done    <= nxt == APPLY;
      cfg_timeout <= nxt == QUIESCE &&
                     qcnt_n == QW'(IDLE_TIMEOUT - 1);
      mac_tx_configuration_vector <=
        vec(active_n, run_en && active_n.tx_en, 1'b1);
      mac_rx_configuration_vector <=
        vec(active_n, run_en && active_n.rx_en, 1'b0);
    end
  end
endmodule

// File: tb/tb_eth_mac_cfg_ctrl.sv
// Scoreboard bench for eth_mac_cfg_ctrl: directed
// register writes, timed vector checks, event queue.
module tb_eth_mac_cfg_ctrl;
  localparam int DRAIN = 4;
  localparam int TMO   = 20;
  localparam logic [47:0] M0 = 48'h001122334455;
  localparam logic [47:0] M1 = 48'h1234AABBCCDD;
  localparam logic [14:0] U0 = 15'd1518;
  localparam logic [14:0] U2 = 15'd9000;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        link_up;
  logic        tx_idle;
  logic        rx_idle;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_timeout;
  logic [79:0] txv;
  logic [79:0] rxv;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    int          c;
    string       name;
    logic [79:0] tx;
    logic [79:0] rx;
    logic        busy;
  } chk_t;

  typedef struct {
    int c;
    bit to;
  } ev_t;

  chk_t chk_q[$];
  ev_t  ev_q[$];

  eth_mac_cfg_ctrl_if bus ();

  eth_mac_cfg_ctrl #(
    .DRAIN_CYCLES(DRAIN),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk156(clk156),
    .sys_rst(sys_rst),
    .host(bus),
    .link_up(link_up),
    .tx_idle(tx_idle),
    .rx_idle(rx_idle),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_timeout(cfg_timeout),
    .mac_tx_configuration_vector(txv),
    .mac_rx_configuration_vector(rxv)
  );

  always #5 clk156 = ~clk156;
  always @(posedge clk156) cyc <= cyc + 1;

  function automatic logic [79:0] vec(
    input logic [47:0] m,
    input logic [14:0] u,
    input logic        en,
    input logic        j,
    input logic        v,
    input logic        tx
  );
    logic [79:0] r;
    r        = '0;
    r[79:32] = m;
    r[30:16] = u;
    r[4]     = j;
    r[2]     = v;
    r[1]     = en;
    if (tx) r[10] = 1'b1;
    else    r[9:8] = 2'b11;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = a;
    bus.cfg_wr_data = d;
    tick(1);
    bus.cfg_wr_en   = 1'b0;
  endtask

  task automatic expect_at(
    input int          c,
    input string       nm,
    input logic [47:0] m,
    input logic [14:0] u,
    input logic        te,
    input logic        re,
    input logic        j,
    input logic        v,
    input logic        b
  );
    chk_t k;
    k.c    = c;
    k.name = nm;
    k.tx   = vec(m, u, te, j, v, 1'b1);
    k.rx   = vec(m, u, re, j, v, 1'b0);
    k.busy = b;
    chk_q.push_back(k);
  endtask

  task automatic ev_at(input int c, input bit to);
    ev_t e;
    e.c  = c;
    e.to = to;
    ev_q.push_back(e);
  endtask

  task automatic pop_ev(input bit to);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s cyc=%0d got pulse required none",
               to ? "timeout" : "done", cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.to != to || e.c != cyc) begin
        failures++;
        $display("FAIL event got %s@%0d required %s@%0d",
                 to ? "timeout" : "done", cyc,
                 e.to ? "timeout" : "done", e.c);
      end
    end
  endtask

  initial forever begin
    chk_t k;
    @(negedge clk156);
    if (cfg_done)    pop_ev(1'b0);
    if (cfg_timeout) pop_ev(1'b1);
    while (chk_q.size() > 0 && chk_q[0].c <= cyc) begin
      k = chk_q.pop_front();
      checks++;
      if (txv !== k.tx || rxv !== k.rx || cfg_busy !== k.busy) begin
        failures++;
        $display("FAIL %s cyc=%0d got tx=%h rx=%h busy=%b required tx=%h rx=%h busy=%b",
                 k.name, cyc, txv, rxv, cfg_busy,
                 k.tx, k.rx, k.busy);
      end
    end
  end

  initial begin
    int n;
    int l;
    sys_rst = 1'b1;
    link_up = 1'b1;
    tx_idle = 1'b1;
    rx_idle = 1'b1;
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_addr = 2'd0;
    bus.cfg_wr_data = 32'd0;
    tick(2);
    sys_rst = 1'b0;
    n = cyc;
    expect_at(n, "reset", M0, U0, 0, 0, 1, 1, 0);
    expect_at(n + 1, "run_pre_en", M0, U0, 0, 0, 1, 1, 0);
    expect_at(n + 2, "run_en", M0, U0, 1, 1, 1, 1, 0);
    tick(3);

    wr(2'd0, 32'hAABBCCDD);
    wr(2'd1, 32'h0000_1234);
    n = cyc;
    expect_at(n, "pre_commit", M0, U0, 1, 1, 1, 1, 0);
    expect_at(n + 1, "quiesce", M0, U0, 0, 0, 1, 1, 1);
    expect_at(n + 7, "apply_run", M1, U0, 1, 1, 1, 1, 0);
    ev_at(n + 6, 1'b0);
    wr(2'd3, 32'h1F);
    tick(9);

    tx_idle = 1'b0;
    wr(2'd2, 32'd9000);
    n = cyc;
    ev_at(n + 20, 1'b1);
    ev_at(n + 25, 1'b0);
    expect_at(n + 21, "drain_after_tmo", M1, U0, 0, 0, 1, 1, 1);
    expect_at(n + 26, "tmo_apply", M1, U2, 1, 0, 1, 1, 0);
    wr(2'd3, 32'h1D);
    tick(28);
    tx_idle = 1'b1;

    n = cyc;
    ev_at(n + 6, 1'b0);
    ev_at(n + 13, 1'b0);
    expect_at(n + 7, "run_one", M1, U2, 1, 1, 0, 1, 0);
    expect_at(n + 8, "requiesce", M1, U2, 0, 0, 0, 1, 1);
    expect_at(n + 14, "second_apply", M1, U2, 1, 1, 0, 1, 0);
    wr(2'd3, 32'h13);
    tick(2);
    wr(2'd3, 32'h1B);
    tick(16);

    n = cyc;
    ev_at(n + 6, 1'b0);
    expect_at(n + 7, "link_drop_down", M1, U2, 0, 0, 1, 1, 0);
    expect_at(n + 9, "down_hold", M1, U2, 0, 0, 1, 1, 0);
    wr(2'd3, 32'h1F);
    tick(2);
    link_up = 1'b0;
    tick(7);
    l = cyc;
    link_up = 1'b1;
    expect_at(l + 1, "link_rise", M1, U2, 0, 0, 1, 1, 0);
    expect_at(l + 2, "link_en", M1, U2, 1, 1, 1, 1, 0);
    tick(5);

    tx_idle = 1'b0;
    n = cyc;
    expect_at(n + 1, "quiesce_b", M1, U2, 0, 0, 1, 1, 1);
    expect_at(n + 4, "mid_reset", M0, U0, 0, 0, 1, 1, 0);
    expect_at(n + 6, "post_reset_run", M0, U0, 1, 1, 1, 1, 0);
    wr(2'd3, 32'h10);
    tick(2);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    tx_idle = 1'b1;
    tick(30);

    link_up = 1'b0;
    tick(3);
    n = cyc;
    ev_at(n + 1, 1'b0);
    expect_at(n + 1, "down_apply", M0, U0, 0, 0, 1, 1, 1);
    expect_at(n + 2, "down_applied", M0, U0, 0, 0, 1, 0, 0);
    wr(2'd3, 32'h17);
    tick(5);

    tick(2);
    checks++;
    if (ev_q.size() != 0 || chk_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got events=%0d checks=%0d required 0",
               ev_q.size(), chk_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
